ifu2dec_buf: RTL
================

Name: ifu2dec_buf

Overview:
- Instruction buffer between the fetch unit (IFU) and the decoder. It sits directly upstream of the decode stage.
- It is a DEPTH-entry valid/ready FIFO. It holds fetched {pc, instr, prdt_taken, fetch error} packets and decouples IFU bus latency from decoder stalls.
- Its contents are flushed on any redirect (jump_flag_i), so no wrong-path instruction reaches decode.

Parameters:
- DEPTH, 2, number of entries; power of two, >= 2.
- AW, 32, PC width.
- IW, 32, instruction width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- if2dec_vld_i  input  1  IFU packet valid.
- if2dec_rdy_i  output  1  buffer can accept a packet this cycle.
- if2dec_pc_i  input  AW  fetched PC.
- if2dec_instr_i  input  IW  fetched instruction.
- if2dec_prdt_taken_i  input  1  IFU predicted the branch taken.
- if2dec_buserr_i  input  1  fetch bus error on this packet.
- if2dec_vld_o  output  1  head entry valid toward decode.
- if2dec_rdy_o  input  1  decode accepts the head entry.
- if2dec_pc_o  output  AW  head PC.
- if2dec_instr_o  output  IW  head instruction.
- if2dec_prdt_taken_o  output  1  head prediction bit.
- if2dec_buserr_o  output  1  head bus-error flag.
- if2dec_cnt_o  output  log2(DEPTH)+1  current occupancy.
- jump_flag_i  input  1  pipeline redirect (branch mispredict, trap, mret); flush request.

Behaviour:
- State:
  - Storage arrays of DEPTH entries.
  - wr_ptr and rd_ptr, log2(DEPTH) bits each, wrap modulo DEPTH.
  - cnt, log2(DEPTH)+1 bits.
- Reset (rst low, asynchronous):
  - wr_ptr = rd_ptr = cnt = 0; all storage = 0.
  - Hence if2dec_vld_o = 0, if2dec_rdy_i = 1, cnt_o = 0, and all data outputs = 0.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Handshake signals:
  - push = if2dec_vld_i & if2dec_rdy_i.
  - pop = if2dec_vld_o & if2dec_rdy_o.
- if2dec_rdy_i = (cnt != DEPTH); combinational from state only.
  - It does not depend on if2dec_rdy_o. There is no pass-through on full.
- if2dec_vld_o = (cnt != 0).
- Data outputs:
  - Combinational read of entry[rd_ptr] when cnt != 0; all zero when empty.
  - They stay stable while vld_o=1 and rdy_o=0.
- Latency: a packet pushed at edge N is visible on the outputs after edge N (one cycle). There is no combinational input-to-output bypass.
- Push: entry[wr_ptr] <= inputs; wr_ptr++.
- Pop: rd_ptr++.
- cnt update:
  - cnt += push - pop.
  - Simultaneous push and pop leave cnt unchanged and both pointers advance.
  - Push and pop are legal together at any occupancy 1..DEPTH-1. At DEPTH only pop is possible, since rdy_i = 0.
- Flush (jump_flag_i = 1 at an edge) has priority over push and pop:
  - wr_ptr = rd_ptr = cnt = 0.
  - Any push in that cycle is dropped.
  - A head entry that decode handshakes in the flush cycle counts as consumed by decode. The buffer does not hold it.
  - if2dec_rdy_i stays state-driven during a flush cycle. The IFU is responsible for ignoring its own in-flight handshake on redirect.
  - Storage contents are not cleared on flush; only valid state is.
- The buffer never reorders or duplicates packets; the FIFO order equals the push order.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.
- Data stored while vld_i=0 or rdy_i=0 is never written.

Test Plan:
- Reset then push pc=0x8000_0000, instr=0x0000_0013 with rdy_o=1 → vld_o=1 on the next cycle with the same pc/instr; it pops and cnt returns to 0; rdy_i stays 1 throughout.
- Hold rdy_o=0 and push pc 0x100, 0x104 (DEPTH=2) → cnt=2, rdy_i=0, and a third push of 0x108 is ignored. Release rdy_o → outputs 0x100 then 0x104 in order, with no 0x108.
- Streaming: vld_i=1 and rdy_o=1 for 10 cycles with pc incrementing by 4 from 0x200 → the outputs show 0x200..0x224 contiguously after one cycle of latency, cnt stays 1, and the pointers wrap with no bubble.
- Full buffer (0x300, 0x304), then jump_flag_i=1 with vld_i=1 (pc 0x308) → next cycle cnt=0, vld_o=0, rdy_i=1, and 0x308 is never output.
- Push with prdt_taken_i=1 and buserr_i=1 → the flags appear unchanged alongside pc on the output and clear with the next packet carrying 0/0.
- Assert rst low asynchronously between edges while cnt=2 → vld_o drops to 0 and cnt_o to 0 before the next clock edge. After release, a push behaves as in the first scenario.

Source files
------------

// File: rtl/ifu2dec_buf.sv
// ifu2dec_buf: fetch-to-decode packet FIFO, flushed on pipeline redirect
module ifu2dec_buf #(
    parameter int DEPTH = 2,
    parameter int AW    = 32,
    parameter int IW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if2dec_vld_i,
    output logic                     if2dec_rdy_i,
    input  logic [AW-1:0]            if2dec_pc_i,
    input  logic [IW-1:0]            if2dec_instr_i,
    input  logic                     if2dec_prdt_taken_i,
    input  logic                     if2dec_buserr_i,
    output logic                     if2dec_vld_o,
    input  logic                     if2dec_rdy_o,
    output logic [AW-1:0]            if2dec_pc_o,
    output logic [IW-1:0]            if2dec_instr_o,
    output logic                     if2dec_prdt_taken_o,
    output logic                     if2dec_buserr_o,
    output logic [$clog2(DEPTH):0]   if2dec_cnt_o,
    input  logic                     jump_flag_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [AW-1:0] pc_q    [DEPTH];
    logic [IW-1:0] instr_q [DEPTH];
    logic          pt_q    [DEPTH];
    logic          be_q    [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          push, pop;
    assign if2dec_rdy_i        = cnt != CW'(DEPTH);
    assign if2dec_vld_o        = cnt != '0;
    assign push                = if2dec_vld_i & if2dec_rdy_i;
    assign pop                 = if2dec_vld_o & if2dec_rdy_o;
    assign if2dec_cnt_o        = cnt;
    assign if2dec_pc_o         = if2dec_vld_o ? pc_q[rd_ptr]    : '0;
    assign if2dec_instr_o      = if2dec_vld_o ? instr_q[rd_ptr] : '0;
    assign if2dec_prdt_taken_o = if2dec_vld_o ? pt_q[rd_ptr]    : 1'b0;
    assign if2dec_buserr_o     = if2dec_vld_o ? be_q[rd_ptr]    : 1'b0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
                pt_q[i]    <= 1'b0;
                be_q[i]    <= 1'b0;
            end
        end else if (jump_flag_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                pc_q[wr_ptr]    <= if2dec_pc_i;
                instr_q[wr_ptr] <= if2dec_instr_i;
                pt_q[wr_ptr]    <= if2dec_prdt_taken_i;
                be_q[wr_ptr]    <= if2dec_buserr_i;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
endmodule
